// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: jump redirect/squash, load-use stall, HALT drain and
// retire/stall performance counters for a short in-order pipeline.
module pipeline_hazard_ctrl #(
    parameter int DataWidth   = 16,
    parameter int RegAddrBits = 3,
    parameter int DrainCycles = 3
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [RegAddrBits-1:0] id_rs,
    input  logic [RegAddrBits-1:0] id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_halt,
    input  logic                   ex_mem_read,
    input  logic [RegAddrBits-1:0] ex_rd,
    input  logic                   ex_jump,
    input  logic [DataWidth-1:0]   ex_target,
    input  logic                   wb_valid,
    output logic                   pc_we,
    output logic                   pc_sel,
    output logic [DataWidth-1:0]   pc_target,
    output logic                   ifid_we,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   halted,
    output logic [DataWidth-1:0]   retired_count,
    output logic [DataWidth-1:0]   stall_count
);

    // state  | meaning
    // RUN    | normal issue; jump squash and load-use stall decoded here
    // DRAIN  | HALT has left ID; bubbles issued while older work retires
    // HALTED | pipeline frozen until reset

    localparam int CntBits = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
    localparam logic [CntBits-1:0]   DrainLoad = CntBits'(DrainCycles - 1);
    localparam logic [CntBits-1:0]   CntOne    = {{(CntBits-1){1'b0}}, 1'b1};
    localparam logic [DataWidth-1:0] CountOne  = {{(DataWidth-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CntBits-1:0] drain_cnt, drain_cnt_nxt;
    logic               rs_hit, rt_hit, load_use, stall_inc;

    // Register 0 is hard-wired, so a load targeting it never blocks a reader.
    assign rs_hit   = id_uses_rs && (id_rs == ex_rd);
    assign rt_hit   = id_uses_rt && (id_rt == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs_hit || rt_hit);

    assign pc_target = ex_target;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        pc_we         = 1'b1;
        pc_sel        = 1'b0;
        ifid_we       = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        halted        = 1'b0;
        stall_inc     = 1'b0;
        case (state)
            RUN: begin
                if (ex_jump) begin
                    pc_sel     = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else if (id_halt) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = DrainLoad;
                end
            end
            DRAIN: begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (drain_cnt == '0) begin
                    state_nxt = HALTED;
                end else begin
                    drain_cnt_nxt = drain_cnt - CntOne;
                end
            end
            HALTED: begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                halted     = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
        // Reset holds the front end frozen and squashed without waiting for a clock.
        if (!RST) begin
            pc_we      = 1'b0;
            pc_sel     = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            halted     = 1'b0;
            stall_inc  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            retired_count <= '0;
            stall_count   <= '0;
        end else begin
            if (wb_valid && (retired_count != '1)) begin
                retired_count <= retired_count + CountOne;
            end
            if (stall_inc && (stall_count != '1)) begin
                stall_count <= stall_count + CountOne;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a cycle-level
// behavioural model; a narrow second instance exercises counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam int DW    = 16;
    localparam int RB    = 3;
    localparam int DRAIN = 3;

    logic          CLK;
    logic          RST;
    logic [RB-1:0] id_rs, id_rt, ex_rd;
    logic          id_uses_rs, id_uses_rt, id_halt, ex_mem_read, ex_jump, wb_valid;
    logic [DW-1:0] ex_target;
    logic          pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, halted;
    logic [DW-1:0] pc_target, retired_count, stall_count;

    logic          sat_wb_valid;
    logic          sat_pc_we, sat_pc_sel, sat_ifid_we, sat_ifid_flush, sat_idex_flush, sat_halted;
    logic [3:0]    sat_pc_target, sat_retired, sat_stall;

    pipeline_hazard_ctrl #(.DataWidth(DW), .RegAddrBits(RB), .DrainCycles(DRAIN)) u_dut (
        .CLK(CLK), .RST(RST),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_jump(ex_jump), .ex_target(ex_target), .wb_valid(wb_valid),
        .pc_we(pc_we), .pc_sel(pc_sel), .pc_target(pc_target),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .retired_count(retired_count), .stall_count(stall_count)
    );

    pipeline_hazard_ctrl #(.DataWidth(4), .RegAddrBits(RB), .DrainCycles(DRAIN)) u_sat (
        .CLK(CLK), .RST(RST),
        .id_rs(3'd0), .id_rt(3'd0), .id_uses_rs(1'b0), .id_uses_rt(1'b0),
        .id_halt(1'b0), .ex_mem_read(1'b0), .ex_rd(3'd0),
        .ex_jump(1'b0), .ex_target(4'd0), .wb_valid(sat_wb_valid),
        .pc_we(sat_pc_we), .pc_sel(sat_pc_sel), .pc_target(sat_pc_target),
        .ifid_we(sat_ifid_we), .ifid_flush(sat_ifid_flush), .idex_flush(sat_idex_flush),
        .halted(sat_halted), .retired_count(sat_retired), .stall_count(sat_stall)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec = 0;
    int n_err = 0;

    // model: 0 = running, 1 = draining, 2 = halted
    int m_mode = 0;
    int m_left = 0;
    int m_ret  = 0;
    int m_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        bit hit;
        hit = (id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd);
        return ex_mem_read && (ex_rd != 0) && hit;
    endfunction

    // {pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, halted}
    function automatic logic [5:0] m_ctrl();
        if (!RST)        return 6'b0_0_0_1_1_0;
        if (m_mode == 2) return 6'b0_0_0_1_1_1;
        if (m_mode == 1) return 6'b0_0_0_1_1_0;
        if (ex_jump)     return 6'b1_1_1_1_1_0;
        if (m_hazard())  return 6'b0_0_0_0_1_0;
        return 6'b1_0_1_0_0_0;
    endfunction

    function automatic logic [5:0] dut_ctrl();
        return {pc_we, pc_sel, ifid_we, ifid_flush, idex_flush, halted};
    endfunction

    task automatic m_reset();
        m_mode = 0; m_left = 0; m_ret = 0; m_stall = 0;
    endtask

    task automatic m_step();
        if (!RST) return;
        if (wb_valid && m_ret < 65535) m_ret++;
        if (m_mode == 0) begin
            if (!ex_jump && m_hazard()) begin
                if (m_stall < 65535) m_stall++;
            end else if (!ex_jump && id_halt) begin
                m_mode = 1;
                m_left = DRAIN;
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0; ex_target = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_halt = 0; ex_mem_read = 0;
        ex_jump = 0; wb_valid = 0;
    endtask

    // Enter at posedge+1 with inputs set; leave at the next posedge+1.
    task automatic tick(input string tag);
        #3;
        check({tag, ".ctrl"}, {26'd0, dut_ctrl()}, {26'd0, m_ctrl()});
        check({tag, ".target"}, {16'd0, pc_target}, {16'd0, ex_target});
        m_step();
        @(posedge CLK);
        #1;
        check({tag, ".retired"}, {16'd0, retired_count}, m_ret);
        check({tag, ".stalls"}, {16'd0, stall_count}, m_stall);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        m_reset();
        check("rst.ctrl", {26'd0, dut_ctrl()}, {26'd0, m_ctrl()});
        check("rst.retired", {16'd0, retired_count}, 0);
        check("rst.stalls", {16'd0, stall_count}, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    initial begin
        RST = 1'b1;
        sat_wb_valid = 1'b0;
        clear_inputs();
        #1;
        do_reset();

        // narrow instance saturates at 4'hF and never wraps
        sat_wb_valid = 1'b1;
        for (int i = 0; i < 14; i++) tick("idle");
        check("sat.pre", {28'd0, sat_retired}, 14);
        for (int i = 0; i < 4; i++) tick("idle");
        check("sat.hold", {28'd0, sat_retired}, 15);
        check("sat.stall", {28'd0, sat_stall}, 0);
        sat_wb_valid = 1'b0;

        // JR redirect then defaults
        ex_jump = 1; ex_target = 16'h0003;
        #3;
        check("jr.pc_sel", {31'd0, pc_sel}, 1);
        check("jr.flush", {30'd0, ifid_flush, idex_flush}, 3);
        #(-3 + 3) tick("jr");
        clear_inputs();
        tick("jr.after");
        check("jr.after.pc_we", {31'd0, pc_we}, 1);

        // load-use stall, then ex_rd = 0 is harmless
        ex_mem_read = 1; ex_rd = 3'd2; id_uses_rt = 1; id_rt = 3'd2;
        tick("lu");
        check("lu.count", {16'd0, stall_count}, 1);
        ex_rd = 3'd0; id_rt = 3'd0;
        tick("lu.r0");
        check("lu.r0.count", {16'd0, stall_count}, 1);

        // jump wins over hazard and halt
        ex_jump = 1; ex_mem_read = 1; ex_rd = 3'd5; id_uses_rs = 1; id_rs = 3'd5; id_halt = 1;
        tick("prio");
        clear_inputs();
        tick("prio.after");
        check("prio.count", {16'd0, stall_count}, 1);

        // five retirements
        do_reset();
        wb_valid = 1;
        for (int i = 0; i < 5; i++) tick("ret");
        wb_valid = 0;
        check("ret.five", {16'd0, retired_count}, 5);

        // halt: one default cycle, three drain cycles, then frozen
        id_halt = 1;
        tick("halt.issue");
        id_halt = 0;
        for (int i = 0; i < DRAIN; i++) begin
            check("halt.drain.halted", {31'd0, halted}, 0);
            tick("halt.drain");
        end
        ex_jump = 1;
        for (int i = 0; i < 22; i++) begin
            check("halt.hold", {30'd0, halted, pc_we}, 2);
            tick("halt.hold");
        end
        clear_inputs();

        // async reset in the middle of a drain
        do_reset();
        wb_valid = 1;
        tick("ar.pre");
        wb_valid = 0;
        id_halt = 1;
        tick("ar.halt");
        id_halt = 0;
        tick("ar.drain");
        #2;
        RST = 1'b0;
        #1;
        m_reset();
        check("ar.halted", {31'd0, halted}, 0);
        check("ar.retired", {16'd0, retired_count}, 0);
        check("ar.ctrl", {26'd0, dut_ctrl()}, {26'd0, m_ctrl()});
        #3;
        RST = 1'b1;
        #1;
        check("ar.release.pc_we", {31'd0, pc_we}, 1);
        @(posedge CLK);
        #1;
        tick("ar.run");
        check("ar.run.halted", {31'd0, halted}, 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            if (m_mode == 2 || $urandom_range(0, 99) == 0) begin
                clear_inputs();
                do_reset();
            end
            ex_rd       = RB'($urandom_range(0, 7));
            id_rs       = RB'($urandom_range(0, 7));
            id_rt       = RB'($urandom_range(0, 7));
            id_uses_rs  = 1'($urandom_range(0, 1));
            id_uses_rt  = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_jump     = ($urandom_range(0, 5) == 0);
            id_halt     = ($urandom_range(0, 29) == 0);
            wb_valid    = 1'($urandom_range(0, 1));
            ex_target   = DW'($urandom);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
